// File: rtl/claw_motion_ctrl.sv
// Claw swing-angle and rope-length controller, stepped once per video frame.
// Optional macro CLAW_EMPTY_BOOST_EN doubles the retract step after an empty (max-length) shot.
module claw_motion_ctrl #(
  parameter int unsigned ANGLE_MAX    = 16,
  parameter int unsigned ANGLE_CENTER = 8,
  parameter int unsigned SWING_DIV    = 2,
  parameter int unsigned MIN_LEN      = 16,
  parameter int unsigned MAX_LEN      = 400
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       level_active,
  input  logic       is_enter_pressed,
  input  logic       claw_collision,
  input  logic [3:0] move_speed,
  output logic [4:0] claw_angle,
  output logic [9:0] claw_length,
  output logic       swing_dir,
  output logic       claw_busy,
  output logic       claw_returned
);

  localparam int unsigned ANG_W  = 5;
  localparam int unsigned LEN_W  = 10;
  localparam int unsigned STEP_W = 5;
  localparam int unsigned CNT_W  = (SWING_DIV > 1) ? $clog2(SWING_DIV) : 1;

  localparam logic [ANG_W-1:0] ANG_MAX_V    = ANG_W'(ANGLE_MAX);
  localparam logic [ANG_W-1:0] ANG_CENTER_V = ANG_W'(ANGLE_CENTER);
  localparam logic [LEN_W-1:0] MIN_LEN_V    = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN_V    = LEN_W'(MAX_LEN);
  localparam logic [LEN_W:0]   MAX_LEN_W    = (LEN_W+1)'(MAX_LEN);
  localparam logic [LEN_W:0]   MIN_LEN_W    = (LEN_W+1)'(MIN_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(SWING_DIV - 1);

  typedef enum logic [1:0] {
    ST_PARK,
    ST_SWING,
    ST_EXTEND,
    ST_RETRACT
  } state_t;

  state_t             state_q, state_d;
  logic [ANG_W-1:0]   angle_d;
  logic [LEN_W-1:0]   length_d;
  logic               dir_d;
  logic               busy_d;
  logic               returned_d;
  logic [CNT_W-1:0]   swing_cnt_q, swing_cnt_d;
  logic [ANG_W-1:0]   angle_stepped;
  logic [LEN_W:0]     extend_sum;
  logic [STEP_W-1:0]  retract_step;
  logic [LEN_W:0]     retract_floor;
`ifdef CLAW_EMPTY_BOOST_EN
  logic               empty_q, empty_d;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= ST_PARK;
      claw_angle    <= ANG_CENTER_V;
      claw_length   <= MIN_LEN_V;
      swing_dir     <= 1'b1;
      claw_busy     <= 1'b0;
      claw_returned <= 1'b0;
      swing_cnt_q   <= '0;
`ifdef CLAW_EMPTY_BOOST_EN
      empty_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      claw_angle    <= angle_d;
      claw_length   <= length_d;
      swing_dir     <= dir_d;
      claw_busy     <= busy_d;
      claw_returned <= returned_d;
      swing_cnt_q   <= swing_cnt_d;
`ifdef CLAW_EMPTY_BOOST_EN
      empty_q       <= empty_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    angle_d     = claw_angle;
    length_d    = claw_length;
    dir_d       = swing_dir;
    returned_d  = 1'b0;
    swing_cnt_d = swing_cnt_q;
`ifdef CLAW_EMPTY_BOOST_EN
    empty_d     = empty_q;
`endif

    // Guarded step keeps the angle inside 0..ANGLE_MAX even from an odd state
    angle_stepped = claw_angle;
    if (swing_dir && (claw_angle < ANG_MAX_V)) begin
      angle_stepped = claw_angle + ANG_W'(1);
    end else if (!swing_dir && (claw_angle != '0)) begin
      angle_stepped = claw_angle - ANG_W'(1);
    end

    extend_sum = {1'b0, claw_length} + (LEN_W+1)'(move_speed);
`ifdef CLAW_EMPTY_BOOST_EN
    retract_step = empty_q ? {move_speed, 1'b0} : STEP_W'(move_speed);
`else
    retract_step = STEP_W'(move_speed);
`endif
    retract_floor = MIN_LEN_W + (LEN_W+1)'(retract_step);

    if (!level_active) begin
      state_d     = ST_PARK;
      angle_d     = ANG_CENTER_V;
      length_d    = MIN_LEN_V;
      dir_d       = 1'b1;
      swing_cnt_d = '0;
`ifdef CLAW_EMPTY_BOOST_EN
      empty_d     = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_PARK: begin
          state_d = ST_SWING;
          dir_d   = 1'b1;
        end

        ST_SWING: begin
          if (is_enter_pressed) begin
            state_d     = ST_EXTEND;
            swing_cnt_d = '0;
          end else if (startOfFrame) begin
            if (swing_cnt_q >= CNT_LAST) begin
              swing_cnt_d = '0;
              angle_d     = angle_stepped;
              if (angle_stepped == ANG_MAX_V) begin
                dir_d = 1'b0;
              end else if (angle_stepped == '0) begin
                dir_d = 1'b1;
              end
            end else begin
              swing_cnt_d = swing_cnt_q + CNT_W'(1);
            end
          end
        end

        ST_EXTEND: begin
          if (claw_collision) begin
            state_d = ST_RETRACT;
`ifdef CLAW_EMPTY_BOOST_EN
            empty_d = 1'b0;
`endif
          end else if (startOfFrame) begin
            if (extend_sum >= MAX_LEN_W) begin
              length_d = MAX_LEN_V;
              state_d  = ST_RETRACT;
`ifdef CLAW_EMPTY_BOOST_EN
              empty_d  = 1'b1;
`endif
            end else begin
              length_d = extend_sum[LEN_W-1:0];
            end
          end
        end

        ST_RETRACT: begin
          if (startOfFrame) begin
            if ({1'b0, claw_length} <= retract_floor) begin
              length_d   = MIN_LEN_V;
              returned_d = 1'b1;
              state_d    = ST_SWING;
            end else begin
              length_d = claw_length - LEN_W'(retract_step);
            end
          end
        end

        default: begin
          state_d = ST_PARK;
        end
      endcase
    end

    busy_d = (state_d == ST_EXTEND) || (state_d == ST_RETRACT);
  end

endmodule

// File: tb/tb_claw_motion_ctrl.sv
// Self-checking bench for claw_motion_ctrl: directed test-plan scenarios plus random stimulus
// compared every cycle against a frame-level behavioural model.
module tb_claw_motion_ctrl;

  localparam int ANGLE_MAX    = 16;
  localparam int ANGLE_CENTER = 8;
  localparam int SWING_DIV    = 2;
  localparam int MIN_LEN      = 16;
  localparam int MAX_LEN      = 400;

  localparam int PH_PARK    = 0;
  localparam int PH_SWING   = 1;
  localparam int PH_EXTEND  = 2;
  localparam int PH_RETRACT = 3;

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic       level_active;
  logic       is_enter_pressed;
  logic       claw_collision;
  logic [3:0] move_speed;
  logic [4:0] claw_angle;
  logic [9:0] claw_length;
  logic       swing_dir;
  logic       claw_busy;
  logic       claw_returned;

  int checks;
  int failures;

  claw_motion_ctrl dut (
    .clk              (clk),
    .resetN           (resetN),
    .startOfFrame     (startOfFrame),
    .level_active     (level_active),
    .is_enter_pressed (is_enter_pressed),
    .claw_collision   (claw_collision),
    .move_speed       (move_speed),
    .claw_angle       (claw_angle),
    .claw_length      (claw_length),
    .swing_dir        (swing_dir),
    .claw_busy        (claw_busy),
    .claw_returned    (claw_returned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int ph;
    int ang;
    int len;
    int dir;
    int frames;
    int ret;
    int empty;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.ph = PH_PARK; r.ang = ANGLE_CENTER; r.len = MIN_LEN; r.dir = 1;
    r.frames = 0; r.ret = 0; r.empty = 0;
    return r;
  endfunction

  // One clock of claw behaviour expressed as frame arithmetic
  function automatic model_t model_step(model_t c, logic la, logic sof, logic ent,
                                        logic col, int spd);
    model_t n = c;
    int step;
    n.ret = 0;
    if (!la) return model_reset();
    case (c.ph)
      PH_PARK: n.ph = PH_SWING;
      PH_SWING: begin
        if (ent) begin
          n.ph = PH_EXTEND; n.frames = 0;
        end else if (sof) begin
          n.frames = c.frames + 1;
          if (n.frames >= SWING_DIV) begin
            n.frames = 0;
            n.ang = c.ang + (c.dir != 0 ? 1 : -1);
            if (n.ang >= ANGLE_MAX) begin n.ang = ANGLE_MAX; n.dir = 0; end
            else if (n.ang <= 0) begin n.ang = 0; n.dir = 1; end
          end
        end
      end
      PH_EXTEND: begin
        if (col) begin
          n.ph = PH_RETRACT; n.empty = 0;
        end else if (sof) begin
          if (c.len + spd >= MAX_LEN) begin
            n.len = MAX_LEN; n.ph = PH_RETRACT; n.empty = 1;
          end else begin
            n.len = c.len + spd;
          end
        end
      end
      default: begin
        if (sof) begin
          step = spd;
`ifdef CLAW_EMPTY_BOOST_EN
          if (c.empty != 0) step = 2 * spd;
`endif
          if (c.len <= MIN_LEN + step) begin
            n.len = MIN_LEN; n.ret = 1; n.ph = PH_SWING;
          end else begin
            n.len = c.len - step;
          end
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge resetN) begin
    if (!resetN) m <= model_reset();
    else m <= model_step(m, level_active, startOfFrame, is_enter_pressed,
                         claw_collision, int'(move_speed));
  end

  task automatic check(input string name, input logic [15:0] act, input int exp);
    checks++;
    if (act !== 16'(exp)) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and compare every output with the model
  task automatic tick();
    int busy;
    @(negedge clk);
    busy = (m.ph == PH_EXTEND || m.ph == PH_RETRACT) ? 1 : 0;
    checks++;
    if (claw_angle !== 5'(m.ang) || claw_length !== 10'(m.len) ||
        swing_dir !== 1'(m.dir) || claw_busy !== 1'(busy) || claw_returned !== 1'(m.ret)) begin
      failures++;
      $display("FAIL cycle t=%0t actual ang=%0d len=%0d dir=%0b busy=%0b ret=%0b required ang=%0d len=%0d dir=%0d busy=%0d ret=%0d",
               $time, claw_angle, claw_length, swing_dir, claw_busy, claw_returned,
               m.ang, m.len, m.dir, busy, m.ret);
    end
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic launch();
    is_enter_pressed = 1'b1;
    tick();
    is_enter_pressed = 1'b0;
    tick();
  endtask

  task automatic collide();
    claw_collision = 1'b1;
    tick();
    claw_collision = 1'b0;
    tick();
  endtask

  task automatic retract_to_end(input int bound);
    for (int i = 0; i < bound && m.ph == PH_RETRACT; i++) frame();
  endtask

  initial begin
    int exp_after_max;
    checks = 0;
    failures = 0;
    resetN = 1'b0;
    startOfFrame = 1'b0;
    level_active = 1'b0;
    is_enter_pressed = 1'b0;
    claw_collision = 1'b0;
    move_speed = 4'd0;
    tick(); tick(); tick();
    check("reset_angle", 16'(claw_angle), 8);
    check("reset_length", 16'(claw_length), 16);
    check("reset_dir", 16'(swing_dir), 1);
    check("reset_busy", 16'(claw_busy), 0);
    check("reset_returned", 16'(claw_returned), 0);
    resetN = 1'b1;

    // Swing and bounce at the right end
    level_active = 1'b1;
    tick();
    frames(2);
    check("swing_first_step", 16'(claw_angle), 9);
    frames(14);
    check("swing_reach_max", 16'(claw_angle), 16);
    check("swing_dir_flip", 16'(swing_dir), 0);
    frames(2);
    check("swing_bounce", 16'(claw_angle), 15);
    frames(6);
    check("swing_at_12", 16'(claw_angle), 12);

    // Launch, collide after 5 frames, retract
    move_speed = 4'd4;
    launch();
    check("launch_busy", 16'(claw_busy), 1);
    frames(5);
    check("extend_36", 16'(claw_length), 36);
    collide();
    check("collide_hold", 16'(claw_length), 36);
    frame(); check("retract_32", 16'(claw_length), 32);
    frame(); check("retract_28", 16'(claw_length), 28);
    frame(); check("retract_24", 16'(claw_length), 24);
    frame(); check("retract_20", 16'(claw_length), 20);
    startOfFrame = 1'b1;
    tick();
    check("returned_len", 16'(claw_length), 16);
    check("returned_pulse", 16'(claw_returned), 1);
    check("returned_idle", 16'(claw_busy), 0);
    startOfFrame = 1'b0;
    tick();
    check("returned_one_clk", 16'(claw_returned), 0);
    check("returned_angle", 16'(claw_angle), 12);

    // Empty shot: saturate at MAX_LEN then auto-retract
    move_speed = 4'd15;
    launch();
    frames(25);
    check("extend_391", 16'(claw_length), 391);
    frame();
    check("saturate_400", 16'(claw_length), 400);
    check("saturate_busy", 16'(claw_busy), 1);
    frame();
`ifdef CLAW_EMPTY_BOOST_EN
    exp_after_max = 370;
`else
    exp_after_max = 385;
`endif
    check("empty_retract_step", 16'(claw_length), exp_after_max);
    retract_to_end(40);
    check("empty_done_busy", 16'(claw_busy), 0);
    check("empty_done_len", 16'(claw_length), 16);

    // Collision and frame on the same clock
    move_speed = 4'd12;
    launch();
    frames(2);
    check("extend_40", 16'(claw_length), 40);
    startOfFrame = 1'b1;
    claw_collision = 1'b1;
    tick();
    startOfFrame = 1'b0;
    claw_collision = 1'b0;
    tick();
    check("collide_sof_len", 16'(claw_length), 40);
    check("collide_sof_busy", 16'(claw_busy), 1);
    frame();
    check("retract_28b", 16'(claw_length), 28);
    startOfFrame = 1'b1;
    tick();
    check("edge_return_pulse", 16'(claw_returned), 1);
    startOfFrame = 1'b0;
    tick();

    // Level drop mid-extend
    move_speed = 4'd14;
    launch();
    frames(6);
    check("extend_100", 16'(claw_length), 100);
    level_active = 1'b0;
    tick();
    check("drop_len", 16'(claw_length), 16);
    check("drop_angle", 16'(claw_angle), 8);
    check("drop_busy", 16'(claw_busy), 0);
    check("drop_no_return", 16'(claw_returned), 0);
    level_active = 1'b1;
    tick();

    // Zero speed freezes retraction
    move_speed = 4'd10;
    launch();
    frames(4);
    collide();
    move_speed = 4'd0;
    frames(10);
    check("freeze_len", 16'(claw_length), 56);
    check("freeze_busy", 16'(claw_busy), 1);
    move_speed = 4'd4;
    frame();
    check("resume_52", 16'(claw_length), 52);
    retract_to_end(20);
    check("resume_done", 16'(claw_busy), 0);

    // Random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      level_active     = ($urandom_range(0, 79) != 0);
      startOfFrame     = ($urandom_range(0, 2) == 0);
      is_enter_pressed = ($urandom_range(0, 9) == 0);
      claw_collision   = ($urandom_range(0, 24) == 0);
      move_speed       = 4'($urandom_range(0, 15));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
